// File: rtl/switch_debouncer_if.sv
// Switch conditioning bus: raw pins in, debounced vector and change pulse out.
// Latency: none (wires only).
// Backpressure: none; all signals are level/pulse, no handshake.
// Optional SWDB_GLITCH_CNT_EN adds the 16-bit aborted-settle counter.
interface switch_debouncer_if #(
    parameter int WIDTH = 64
);
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_stable;
    logic             sw_changed;
`ifdef SWDB_GLITCH_CNT_EN
    logic [15:0]      glitch_cnt;

    modport master (
        output sw_raw,
        input  sw_stable,
        input  sw_changed,
        input  glitch_cnt
    );

    modport slave (
        input  sw_raw,
        output sw_stable,
        output sw_changed,
        output glitch_cnt
    );
`else
    modport master (
        output sw_raw,
        input  sw_stable,
        input  sw_changed
    );

    modport slave (
        input  sw_raw,
        output sw_stable,
        output sw_changed
    );
`endif
endinterface

// File: rtl/switch_debouncer.sv
// Synchronise raw switch pins, whole-vector debounce, one-cycle change pulse.
// Latency: level change first sampled at edge E0 appears on sw_stable at E0+STABLE_CYCLES+2.
// Backpressure: none; the output vector is always valid, sw_changed is a bare pulse.
// Optional SWDB_GLITCH_CNT_EN enables a saturating 16-bit aborted-settle counter.
module switch_debouncer #(
    parameter int WIDTH         = 64,
    parameter int STABLE_CYCLES = 20000,
    parameter bit RESET_VAL     = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    switch_debouncer_if.slave bus
);

    // STABLE_CYCLES must be at least 1; counter holds 0..STABLE_CYCLES-1.
    localparam int                 CW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]      CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [WIDTH-1:0]   RST_VEC  = {WIDTH{RESET_VAL}};

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  sync1;
    logic [WIDTH-1:0]  sync2;
    logic [WIDTH-1:0]  cand;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  stable_q;
    logic              changed_q;

    // Two-flop synchroniser bringing the asynchronous pins into clk
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= RST_VEC;
            sync2 <= RST_VEC;
        end else begin
            sync1 <= bus.sw_raw;
            sync2 <= sync1;
        end
    end

    // Settle FSM: any bit change restarts the window for the whole vector
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cand      <= RST_VEC;
            cnt       <= '0;
            stable_q  <= RST_VEC;
            changed_q <= 1'b0;
        end else begin
            changed_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (sync2 != cand) begin
                        cand  <= sync2;
                        cnt   <= '0;
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    if (sync2 != cand) begin
                        // Bounce wins over a coincident expiry
                        cand <= sync2;
                        cnt  <= '0;
                    end else if (cnt == CNT_LAST) begin
                        // Settling back to the old value rewrites it silently
                        stable_q  <= cand;
                        changed_q <= (cand != stable_q);
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sw_stable  = stable_q;
    assign bus.sw_changed = changed_q;

`ifdef SWDB_GLITCH_CNT_EN
    logic [15:0] glitch_q;
    logic        bounce;
    logic        same_expiry;

    assign bounce      = (state == COUNT) && (sync2 != cand);
    assign same_expiry = (state == COUNT) && (sync2 == cand) &&
                         (cnt == CNT_LAST) && (cand == stable_q);

    // Count aborted settles (restarts and no-change expiries), saturating
    always_ff @(posedge clk) begin
        if (reset) begin
            glitch_q <= '0;
        end else if ((bounce || same_expiry) && (glitch_q != 16'hFFFF)) begin
            glitch_q <= glitch_q + 16'd1;
        end
    end

    assign bus.glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with a run-length reference model.
// Latency: model tracks the 2-edge synchroniser delay plus the settle window.
// Backpressure: n/a; inputs change on the falling edge, outputs sampled there too.
module tb_switch_debouncer;

    localparam int W = 64;
    localparam int S = 4;
    localparam logic [W-1:0] ONES = {W{1'b1}};

    logic clk;
    logic reset;

    switch_debouncer_if #(.WIDTH(W)) bus();

    switch_debouncer #(
        .WIDTH(W),
        .STABLE_CYCLES(S),
        .RESET_VAL(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int pulses = 0;
    int last_pulse = -1;
    bit chk_en = 1'b0;

    // Reference model: filter input is the raw vector two edges back; a change
    // opens a settle window that closes after S further identical samples.
    logic [W-1:0] m_d1 = ONES;
    logic [W-1:0] m_d2 = ONES;
    logic [W-1:0] m_prev = ONES;
    logic [W-1:0] m_stable = ONES;
    logic         m_changed = 1'b0;
    bit           m_pending = 1'b0;
    int           m_run = 0;
    logic [15:0]  m_glitch = 16'h0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Advance the model on each rising edge from the pre-edge inputs
    always @(posedge clk) begin
        logic [W-1:0] s;
        cyc++;
        if (reset) begin
            m_d1 = ONES; m_d2 = ONES; m_prev = ONES; m_stable = ONES;
            m_changed = 1'b0; m_pending = 1'b0; m_run = 0; m_glitch = 16'h0;
        end else begin
            s = m_d2;
            m_changed = 1'b0;
            if (s != m_prev) begin
                if (m_pending && m_glitch != 16'hFFFF) m_glitch++;
                m_pending = 1'b1;
                m_run = 1;
            end else if (m_pending) begin
                m_run++;
                if (m_run == S + 1) begin
                    if (s == m_stable && m_glitch != 16'hFFFF) m_glitch++;
                    m_changed = (s != m_stable);
                    m_stable = s;
                    m_pending = 1'b0;
                end
            end
            m_prev = s;
            m_d2 = m_d1;
            m_d1 = bus.sw_raw;
        end
    end

    // Per-cycle compare of DUT outputs against the model, plus pulse logging
    always @(negedge clk) begin
        if (chk_en) begin
            check("sw_stable", bus.sw_stable, m_stable);
            check("sw_changed", 64'(bus.sw_changed), 64'(m_changed));
`ifdef SWDB_GLITCH_CNT_EN
            check("glitch_cnt", 64'(bus.glitch_cnt), 64'(m_glitch));
`endif
        end
        if (bus.sw_changed === 1'b1) begin
            pulses++;
            last_pulse = cyc;
        end
    end

    initial begin
        int e0;
        int p0;
        logic [15:0] g0;

        reset = 1'b1;
        bus.sw_raw = ONES;
        cycles(2);
        chk_en = 1'b1;
        reset = 1'b0;
        check("reset_stable", bus.sw_stable, 64'hFFFF_FFFF_FFFF_FFFF);
        check("reset_changed", 64'(bus.sw_changed), 64'h0);
`ifdef SWDB_GLITCH_CNT_EN
        check("reset_glitch", 64'(bus.glitch_cnt), 64'h0);
`endif
        cycles(3);

        // Clean single-bit change: update at E0+S+2
        bus.sw_raw[0] = 1'b0;
        e0 = cyc + 1;
        p0 = pulses;
        cycles(12);
        check("clean_edge", 64'(last_pulse), 64'(e0 + 6));
        check("clean_pulses", 64'(pulses - p0), 64'd1);
        check("clean_stable", bus.sw_stable, 64'hFFFF_FFFF_FFFF_FFFE);

        // Bit5 bouncing every 2 cycles, then held low
        p0 = pulses;
`ifdef SWDB_GLITCH_CNT_EN
        g0 = bus.glitch_cnt;
`else
        g0 = 16'h0;
`endif
        for (int i = 0; i < 6; i++) begin
            bus.sw_raw[5] = (i % 2 == 0) ? 1'b0 : 1'b1;
            cycles(2);
        end
        bus.sw_raw[5] = 1'b0;
        e0 = cyc + 1;
        cycles(12);
        check("bounce_edge", 64'(last_pulse), 64'(e0 + 6));
        check("bounce_pulses", 64'(pulses - p0), 64'd1);
        check("bounce_stable", bus.sw_stable, 64'hFFFF_FFFF_FFFF_FFDE);
`ifdef SWDB_GLITCH_CNT_EN
        check("bounce_glitch", 64'(bus.glitch_cnt - g0), 64'd6);
`endif

        // Bit63 short low pulse: settles back to the old value, no pulse
        p0 = pulses;
`ifdef SWDB_GLITCH_CNT_EN
        g0 = bus.glitch_cnt;
`endif
        bus.sw_raw[63] = 1'b0;
        cycles(3);
        bus.sw_raw[63] = 1'b1;
        cycles(14);
        check("return_pulses", 64'(pulses - p0), 64'd0);
        check("return_stable", bus.sw_stable, 64'hFFFF_FFFF_FFFF_FFDE);
`ifdef SWDB_GLITCH_CNT_EN
        check("return_glitch", 64'(bus.glitch_cnt - g0), 64'd2);
`endif

        // Reset in the middle of a settle window
        p0 = pulses;
        bus.sw_raw[10] = 1'b0;
        cycles(3);
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        check("midrst_pulses", 64'(pulses - p0), 64'd0);
        check("midrst_stable", bus.sw_stable, 64'hFFFF_FFFF_FFFF_FFFF);
`ifdef SWDB_GLITCH_CNT_EN
        check("midrst_glitch", 64'(bus.glitch_cnt), 64'h0);
`endif
        e0 = cyc + 1;
        cycles(12);
        check("postrst_edge", 64'(last_pulse), 64'(e0 + 6));
        check("postrst_pulses", 64'(pulses - p0), 64'd1);
        check("postrst_stable", bus.sw_stable, 64'hFFFF_FFFF_FFFF_FBDE);

`ifdef SWDB_GLITCH_CNT_EN
        // Saturation of the aborted-settle counter
        chk_en = 1'b0;
        force dut.glitch_q = 16'hFFFE;
        m_glitch = 16'hFFFE;
        cycles(1);
        release dut.glitch_q;
        cycles(1);
        chk_en = 1'b1;
        p0 = pulses;
        bus.sw_raw[1] = 1'b0;
        cycles(1);
        bus.sw_raw[1] = 1'b1;
        cycles(1);
        bus.sw_raw[1] = 1'b0;
        cycles(1);
        bus.sw_raw[1] = 1'b1;
        cycles(14);
        check("sat_glitch", 64'(bus.glitch_cnt), 64'hFFFF);
        check("sat_pulses", 64'(pulses - p0), 64'd0);
`endif

        cycles(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
